// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EX entry, waits for load data, feeds WB.
// Ports: clk, reset (sync, active-low), EX/WB valid-allow handshake,
//   data SRAM response (rdata/data_ok), WB bus, ID forward, load-busy.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_allow,
  output logic        MEM_allow,
  input  logic        EX_to_MEM_valid,
  input  logic [70:0] EX_to_MEM_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_data_ok,
  output logic        MEM_to_WB_valid,
  output logic [69:0] MEM_to_WB_bus,
  output logic [37:0] MEM_to_ID_forward,
  output logic        MEM_to_ID_load_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [70:0] MEM_bus_reg;
  logic        MEM_valid;
  logic [31:0] rdata_buf;

  logic        is_load;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        MEM_ready_go;
  logic [31:0] final_result;
  logic        accept;
  logic        accept_load;
  logic        data_hit;

  assign is_load    = MEM_bus_reg[70];
  assign gr_we      = MEM_bus_reg[69];
  assign dest       = MEM_bus_reg[68:64];
  assign alu_result = MEM_bus_reg[63:32];
  assign pc         = MEM_bus_reg[31:0];

  // data_ok only counts while a load is actually waiting
  assign data_hit = (state == WAIT) && data_sram_data_ok;

  always_comb begin
    MEM_ready_go = 1'b1;
    final_result = alu_result;
    if (is_load) begin
      unique case (state)
        HOLD: begin
          MEM_ready_go = 1'b1;
          final_result = rdata_buf;
        end
        WAIT: begin
          MEM_ready_go = data_sram_data_ok;
          final_result = data_sram_rdata;
        end
        default: begin
          MEM_ready_go = 1'b0;
          final_result = alu_result;
        end
      endcase
    end
  end

  assign MEM_allow   = !MEM_valid || (MEM_ready_go && WB_allow);
  assign accept      = EX_to_MEM_valid && MEM_allow;
  assign accept_load = accept && EX_to_MEM_bus[70];

  assign MEM_to_WB_valid     = MEM_valid && MEM_ready_go;
  assign MEM_to_WB_bus       = {gr_we, dest, final_result, pc};
  assign MEM_to_ID_forward   = {gr_we & MEM_valid,
                                dest & {5{MEM_valid}},
                                final_result};
  assign MEM_to_ID_load_busy = MEM_valid && is_load && !MEM_ready_go;

  always_ff @(posedge clk) begin
    if (!reset) begin
      MEM_valid   <= 1'b0;
      MEM_bus_reg <= '0;
      rdata_buf   <= '0;
      state       <= IDLE;
    end else begin
      if (MEM_allow) MEM_valid <= EX_to_MEM_valid;
      if (accept) MEM_bus_reg <= EX_to_MEM_bus;
      if (data_hit) rdata_buf <= data_sram_rdata;

      // a newly accepted load always restarts the wait
      if (accept_load) begin
        state <= WAIT;
      end else begin
        unique case (state)
          WAIT: if (data_hit) state <= WB_allow ? IDLE : HOLD;
          HOLD: if (WB_allow) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors, expected WB entries
// queued at issue time, a negedge monitor pops them on each WB transfer.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_allow;
  logic        MEM_allow;
  logic        EX_to_MEM_valid;
  logic [70:0] EX_to_MEM_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [37:0] MEM_to_ID_forward;
  logic        MEM_to_ID_load_busy;

  int checks = 0;
  int errors = 0;
  logic [69:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .WB_allow            (WB_allow),
    .MEM_allow           (MEM_allow),
    .EX_to_MEM_valid     (EX_to_MEM_valid),
    .EX_to_MEM_bus       (EX_to_MEM_bus),
    .data_sram_rdata     (data_sram_rdata),
    .data_sram_data_ok   (data_sram_data_ok),
    .MEM_to_WB_valid     (MEM_to_WB_valid),
    .MEM_to_WB_bus       (MEM_to_WB_bus),
    .MEM_to_ID_forward   (MEM_to_ID_forward),
    .MEM_to_ID_load_busy (MEM_to_ID_load_busy)
  );

  task automatic chk(input string name, input logic [69:0] act,
                     input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [70:0] ex(input logic ld, input logic we,
      input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc);
    return {ld, we, d, alu, pc};
  endfunction

  function automatic logic [69:0] wb(input logic we, input logic [4:0] d,
      input logic [31:0] res, input logic [31:0] pc);
    return {we, d, res, pc};
  endfunction

  // monitor: every WB transfer must match the head of the queue
  always @(negedge clk) begin
    if (reset === 1'b1 && MEM_to_WB_valid === 1'b1 && WB_allow === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected got %h want none", MEM_to_WB_bus);
      end else begin
        chk("wb_bus", MEM_to_WB_bus, exp_q.pop_front());
      end
    end
  end

  task automatic idle_chk(input string name);
    chk({name, "_wbv"}, 70'(MEM_to_WB_valid), 70'd0);
    chk({name, "_allow"}, 70'(MEM_allow), 70'd1);
    chk({name, "_busy"}, 70'(MEM_to_ID_load_busy), 70'd0);
    chk({name, "_fwdhi"}, 70'(MEM_to_ID_forward[37:32]), 70'd0);
  endtask

  initial begin
    reset = 1'b0;
    WB_allow = 1'b1;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus = '0;
    data_sram_rdata = '0;
    data_sram_data_ok = 1'b0;
    cyc();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd9, 32'h0, 32'h0);
    @(negedge clk);
    idle_chk("rst");
    cyc();
    EX_to_MEM_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    idle_chk("post_rst");

    // non-load flow, two back-to-back entries
    cyc();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b0, 1'b1, 5'd5, 32'h1234, 32'h100);
    exp_q.push_back(wb(1'b1, 5'd5, 32'h1234, 32'h100));
    cyc();
    EX_to_MEM_bus = ex(1'b0, 1'b0, 5'd2, 32'h5678, 32'h104);
    exp_q.push_back(wb(1'b0, 5'd2, 32'h5678, 32'h104));
    @(negedge clk);
    chk("fwd_nonload", 70'(MEM_to_ID_forward), 70'h25_0000_1234);
    chk("nl_allow", 70'(MEM_allow), 70'd1);
    cyc();
    EX_to_MEM_valid = 1'b0;
    cyc();
    @(negedge clk);
    idle_chk("nl_done");

    // load with a wait
    cyc();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd7, 32'hAAAA, 32'h200);
    cyc();
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    chk("ld_busy1", 70'(MEM_to_ID_load_busy), 70'd1);
    chk("ld_allow1", 70'(MEM_allow), 70'd0);
    chk("ld_wbv1", 70'(MEM_to_WB_valid), 70'd0);
    cyc();
    @(negedge clk);
    chk("ld_busy2", 70'(MEM_to_ID_load_busy), 70'd1);
    chk("ld_allow2", 70'(MEM_allow), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEADBEEF;
    exp_q.push_back(wb(1'b1, 5'd7, 32'hDEADBEEF, 32'h200));
    @(negedge clk);
    chk("ld_fwd", 70'(MEM_to_ID_forward), {32'h0, 1'b1, 5'd7, 32'hDEADBEEF});
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    idle_chk("ld_done");

    // backpressure: data arrives while WB stalls
    cyc();
    WB_allow = 1'b0;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd3, 32'h55, 32'h300);
    cyc();
    EX_to_MEM_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("bp_wbv", 70'(MEM_to_WB_valid), 70'd1);
    chk("bp_res0", 70'(MEM_to_WB_bus[63:32]), 70'hCAFEF00D);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    chk("hold_wbv", 70'(MEM_to_WB_valid), 70'd1);
    chk("hold_bus", MEM_to_WB_bus, wb(1'b1, 5'd3, 32'hCAFEF00D, 32'h300));
    chk("hold_busy", 70'(MEM_to_ID_load_busy), 70'd0);
    chk("hold_allow", 70'(MEM_allow), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111;
    @(negedge clk);
    chk("hold_stray", 70'(MEM_to_WB_bus[63:32]), 70'hCAFEF00D);
    cyc();
    data_sram_data_ok = 1'b0;
    WB_allow = 1'b1;
    exp_q.push_back(wb(1'b1, 5'd3, 32'hCAFEF00D, 32'h300));
    cyc();
    @(negedge clk);
    idle_chk("bp_done");

    // back-to-back loads, second accepted on first one's data_ok
    cyc();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd4, 32'h0, 32'h400);
    cyc();
    EX_to_MEM_valid = 1'b0;
    cyc();
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd6, 32'h0, 32'h404);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11112222;
    exp_q.push_back(wb(1'b1, 5'd4, 32'h11112222, 32'h400));
    @(negedge clk);
    chk("b2b_allow", 70'(MEM_allow), 70'd1);
    cyc();
    EX_to_MEM_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 70'(MEM_to_ID_load_busy), 70'd1);
    chk("b2b_wbv", 70'(MEM_to_WB_valid), 70'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h33334444;
    exp_q.push_back(wb(1'b1, 5'd6, 32'h33334444, 32'h404));
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    idle_chk("b2b_done");

    // stray data_ok while idle
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h9999;
    @(negedge clk);
    idle_chk("stray");
    cyc();
    data_sram_data_ok = 1'b0;

    // reset while waiting discards the load
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b1, 1'b1, 5'd8, 32'h0, 32'h500);
    cyc();
    EX_to_MEM_valid = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    idle_chk("rst_wait");
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h77;
    @(negedge clk);
    idle_chk("rst_stray");
    cyc();
    data_sram_data_ok = 1'b0;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = ex(1'b0, 1'b1, 5'd1, 32'hBEEF, 32'h600);
    exp_q.push_back(wb(1'b1, 5'd1, 32'hBEEF, 32'h600));
    cyc();
    EX_to_MEM_valid = 1'b0;
    cyc();
    cyc();

    chk("queue_empty", 70'(exp_q.size()), 70'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
